// File: rtl/simon_sequence_checker.sv
// Memory-game pattern store: appends generator symbols, replays them over valid/ready, checks key presses.
// Optional key-wait timeout is compiled in with SIMON_TIMEOUT_EN.
module simon_sequence_checker #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              gen_valid,
    input  logic [1:0]        gen_value,
    input  logic              play_ready,
    output logic              play_valid,
    output logic [1:0]        play_value,
    input  logic              key_valid,
    input  logic [1:0]        key_value,
    output logic [ADDR_W:0]   round_len,
    output logic              round_ok,
    output logic              fail,
    output logic              win,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPEND = 3'd1,
        PLAY   = 3'd2,
        CHECK  = 3'd3,
        FAIL   = 3'd4,
        WIN    = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      mem_r [DEPTH];
    logic [ADDR_W:0] len_r;
    logic [ADDR_W:0] len_s;
    logic [ADDR_W:0] idx_r;
    logic [ADDR_W:0] idx_s;
    logic            mem_we_s;
    logic            round_ok_s;
    logic [1:0]      rd_s;
    logic            idx_last_s;
    logic            key_match_s;
    logic            timeout_s;

    assign idx_last_s  = (idx_r == (len_r - ONE_L));
    assign key_match_s = (key_value == mem_r[idx_r[ADDR_W-1:0]]);
    assign round_len   = len_r;

`ifdef SIMON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT_L = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] tcnt_r;
    logic [TO_W-1:0] tcnt_s;

    // Key-wait timer: runs only while waiting for a key in CHECK, zero otherwise.
    always_comb begin
        tcnt_s    = '0;
        timeout_s = 1'b0;
        if (state_r == CHECK && !key_valid) begin
            tcnt_s    = tcnt_r + TO_W'(1);
            timeout_s = (tcnt_s == TO_LIMIT_L);
        end else begin
            tcnt_s    = '0;
            timeout_s = 1'b0;
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_r <= '0;
        end else begin
            tcnt_r <= tcnt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, pointer and round-result decode; start overrides everything.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        idx_s      = idx_r;
        mem_we_s   = 1'b0;
        round_ok_s = 1'b0;
        if (start) begin
            state_s = APPEND;
            len_s   = '0;
            idx_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                APPEND: begin
                    if (gen_valid) begin
                        mem_we_s = 1'b1;
                        len_s    = len_r + ONE_L;
                        idx_s    = '0;
                        state_s  = PLAY;
                    end else begin
                        state_s = APPEND;
                    end
                end
                PLAY: begin
                    if (play_ready) begin
                        if (idx_last_s) begin
                            idx_s   = '0;
                            state_s = CHECK;
                        end else begin
                            idx_s = idx_r + ONE_L;
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                CHECK: begin
                    if (key_valid) begin
                        if (!key_match_s) begin
                            state_s = FAIL;
                        end else if (idx_last_s) begin
                            if (len_r == DEPTH_L) begin
                                state_s = WIN;
                            end else begin
                                round_ok_s = 1'b1;
                                state_s    = APPEND;
                            end
                        end else begin
                            idx_s = idx_r + ONE_L;
                        end
                    end else if (timeout_s) begin
                        state_s = FAIL;
                    end else begin
                        state_s = CHECK;
                    end
                end
                FAIL: begin
                    state_s = FAIL;
                end
                WIN: begin
                    state_s = WIN;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Symbol presented next cycle; bypass the store when entry 0 is being written right now.
    always_comb begin
        rd_s = 2'd0;
        if (mem_we_s && (idx_s == len_r)) begin
            rd_s = gen_value;
        end else begin
            rd_s = mem_r[idx_s[ADDR_W-1:0]];
        end
    end

    // State, pointers, pattern store and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            len_r      <= '0;
            idx_r      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'd0;
            end
            play_valid <= 1'b0;
            play_value <= 2'd0;
            round_ok   <= 1'b0;
            fail       <= 1'b0;
            win        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            idx_r   <= idx_s;
            if (mem_we_s) begin
                mem_r[len_r[ADDR_W-1:0]] <= gen_value;
            end
            play_valid <= (state_s == PLAY);
            play_value <= (state_s == PLAY) ? rd_s : 2'd0;
            round_ok   <= round_ok_s;
            fail       <= (state_s == FAIL);
            win        <= (state_s == WIN);
            busy       <= !((state_s == IDLE) || (state_s == FAIL) || (state_s == WIN));
        end
    end

endmodule
